axi_frame_tx: RTL

//  Upstream framer for the channelizer FIFOs. Accepts an untagged AXI-stream,

---
 rtl/axi_frame_tx.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_frame_tx.sv
// axi_frame_tx: frames an untagged AXI-stream into len-beat frames for the
// channelizer FIFOs. tlast is inserted every frame_len beats. almost_full is
// honoured only at frame boundaries. A 2-entry skid buffer decouples the
// registered s_axis_tready from m_axis_tready.
// Optional build macro: AXI_FRAME_TX_ZERO_PAD_EN (zero-pad the frame when
// enable drops mid-frame; otherwise the frame is completed with real input).
module axi_frame_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  fifo_almost_full,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [31:0]           frame_cnt,
  output logic                  busy
);

`ifdef AXI_FRAME_TX_ZERO_PAD_EN
  typedef enum logic [1:0] {StIdle, StHold, StRun, StPad} state_e;
`else
  typedef enum logic [1:0] {StIdle, StHold, StRun} state_e;
`endif

  localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic                   stop_q, stop_d;
  logic                   ready_q, ready_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  data0_q, data0_d, data1_q, data1_d;
  logic                   last0_q, last0_d, last1_q, last1_d;
  logic [31:0]            frame_cnt_q, frame_cnt_d;

  logic                   s_acc, is_last, push, push_last, pop;
  logic [DATA_WIDTH-1:0]  push_data;
  logic [LEN_WIDTH-1:0]   new_len;

  assign s_acc   = s_axis_tvalid & ready_q;
  assign is_last = (beat_q == len_q - LenOne);
  assign new_len = (frame_len == '0) ? LenOne : frame_len;
  assign pop     = (cnt_q != 2'd0) & m_axis_tready;

  // Framing FSM: decides what (if anything) enters the skid buffer this cycle.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    stop_d    = stop_q;
    push      = 1'b0;
    push_data = '0;
    push_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          len_d   = new_len;
          beat_d  = '0;
          stop_d  = 1'b0;
          state_d = fifo_almost_full ? StHold : StRun;
        end
      end
      StHold: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (!fifo_almost_full) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (s_acc) begin
          push      = 1'b1;
          push_data = s_axis_tdata;
          push_last = is_last;
          if (is_last) begin
            beat_d = '0;
            if (!enable || stop_q) begin
              state_d = StIdle;
              stop_d  = 1'b0;
            end else begin
              len_d   = new_len;
              state_d = fifo_almost_full ? StHold : StRun;
            end
          end else begin
            beat_d = beat_q + LenOne;
`ifdef AXI_FRAME_TX_ZERO_PAD_EN
            if (!enable) state_d = StPad;
`else
            if (!enable) stop_d = 1'b1;
`endif
          end
        end else if (!enable) begin
          // No beat of this frame taken yet: nothing to finish.
          if (beat_q == '0) begin
            state_d = StIdle;
            stop_d  = 1'b0;
          end else begin
`ifdef AXI_FRAME_TX_ZERO_PAD_EN
            state_d = StPad;
`else
            stop_d  = 1'b1;
`endif
          end
        end
      end
`ifdef AXI_FRAME_TX_ZERO_PAD_EN
      StPad: begin
        if (cnt_q != 2'd2) begin
          push      = 1'b1;
          push_last = is_last;
          if (is_last) begin
            beat_d  = '0;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + LenOne;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Skid buffer next state; entry 0 is the head driven onto m_axis.
  always_comb begin
    cnt_d   = cnt_q;
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          data0_d = push_data;
          last0_d = push_last;
        end else begin
          data1_d = push_data;
          last1_d = push_last;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          data0_d = push_data;
          last0_d = push_last;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = push_data;
          last1_d = push_last;
        end
      end
      default: ;
    endcase
    // Registered ready: a free entry after this cycle guarantees room next cycle.
    ready_d     = (state_d == StRun) && (cnt_d != 2'd2);
    frame_cnt_d = frame_cnt_q + {31'b0, pop & last0_q};
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q     <= StIdle;
      len_q       <= LenOne;
      beat_q      <= '0;
      stop_q      <= 1'b0;
      ready_q     <= 1'b0;
      cnt_q       <= 2'd0;
      data0_q     <= '0;
      data1_q     <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      stop_q      <= stop_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tdata  = data0_q;
  assign m_axis_tlast  = last0_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = (state_q != StIdle) || (cnt_q != 2'd0);

endmodule
